sm_ctrl: RTL and testbench
==========================

Name: sm_ctrl

Overview:
- Parametrised multi-cycle core control FSM: next generation of the fetch/load/store/exec sequencer.
- Sequences the IFU and LSU through valid/ready request handshakes and collects their responses.
- Generates pc/reg write strobes.
- Adds bus timeouts, error traps, debug halt/resume and a retired-instruction counter.
- Sits between the decoder (inst_type) and the IFU/LSU bus masters inside the core.

Parameters:
- START_DELAY, 10: cycles spent in START after reset release before the first fetch request.
- TIMEOUT, 64: maximum cycles waiting for a response in FETCH/LOAD/STORE; 0 disables the timeout.
- INST_TYPE_W, 4: width of inst_type.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous reset, active-low.
- inst_type  in  INST_TYPE_W  decoded class of the current instruction; valid when ifu_respValid=1.
- ifu_reqReady  in  1  IFU accepts the fetch request.
- ifu_respValid  in  1  fetch data valid.
- ifu_respErr  in  1  fetch bus error; qualified by ifu_respValid.
- lsu_reqReady  in  1  LSU accepts the request.
- lsu_respValid  in  1  LSU response valid.
- lsu_respErr  in  1  LSU bus error; qualified by lsu_respValid.
- halt_req  in  1  debug halt request, level-sensitive.
- ifu_reqValid  out  1  fetch request, registered.
- lsu_reqValid  out  1  LSU request, registered.
- lsu_wen  out  1  LSU request is a store, registered; valid with lsu_reqValid.
- pc_wen  out  1  combinational one-cycle PC update strobe.
- reg_wen  out  1  combinational one-cycle register-file write strobe.
- halted  out  1  registered; high in HALT.
- trap  out  1  registered; high in TRAP.
- trap_cause  out  2  0 none, 1 fetch error, 2 LSU error, 3 timeout.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=START; delay and timeout counters cleared.
  - All registered outputs 0, trap_cause=0, retired=0.
  - Reset asserted mid-transaction abandons it immediately; no strobes are issued.
- States: START, FETCH, LOAD, STORE, EXEC, HALT, TRAP.
- START: after START_DELAY cycles → FETCH with ifu_reqValid set on the same edge.
- Request handshake (both IFU and LSU):
  - reqValid is held until sampled with reqReady=1 at a rising edge, then cleared on that edge.
  - lsu_wen follows lsu_reqValid.
  - respValid is ignored while the request is still pending. A response becomes eligible from the cycle after acceptance.
- FETCH, on an eligible ifu_respValid:
  - ifu_respErr=1 → TRAP, cause 1, no strobes.
  - Otherwise pc_wen=1 in that cycle, then by inst_type:
    - INST_LOAD_BYTE/HALF/WORD → LOAD, with lsu_reqValid set and lsu_wen cleared.
    - INST_STORE → STORE, with lsu_reqValid and lsu_wen set.
    - INST_EBREAK → HALT; the instruction retires.
    - Any other type → EXEC with reg_wen=1.
- LOAD, on an eligible lsu_respValid:
  - Error → TRAP, cause 2.
  - Otherwise reg_wen=1 → EXEC.
- STORE, on an eligible lsu_respValid:
  - Error → TRAP, cause 2.
  - Otherwise → EXEC, no reg_wen.
- EXEC:
  - Increment retired, wrapping modulo 2^CNT_W.
  - If halt_req=1 → HALT; otherwise → FETCH with ifu_reqValid set.
  - halt_req is sampled only in EXEC and START; it never aborts a bus transaction.
- HALT: halted=1; when halt_req=0 → FETCH with ifu_reqValid set and halted cleared.
- EBREAK halt: entering HALT via EBREAK also increments retired once. With halt_req=0 the FSM resumes on the next cycle.
- Timeout:
  - The counter clears on entry to FETCH/LOAD/STORE and counts every cycle in those states, including cycles where the request is pending.
  - With TIMEOUT>0, reaching TIMEOUT cycles with no eligible response → TRAP, cause 3.
  - A response arriving in the same cycle as the terminal count wins over the timeout.
- TRAP: sticky; all requests deasserted, no strobes. Only reset exits.
- Unknown/illegal state encoding → TRAP, cause 3; the FSM never wedges.

Decomposition:
- Shared package (existing defs): state encoding, the INST_* type constants (add INST_EBREAK), and the trap cause codes.
- Natural sub-module: bus_hs_tracker, one instance each for IFU and LSU.
  - Holds the pending request, computes response eligibility and runs the timeout counter.
  - Parametrised by TIMEOUT.

Test Plan:
- Reset release, ifu_reqReady=1, ALU-type response 3 cycles after acceptance:
  - ifu_reqValid rises after 10 cycles in START.
  - pc_wen and reg_wen pulse together for 1 cycle.
  - EXEC increments retired to 1; a new fetch is issued.
- INST_LOAD_WORD with lsu_reqReady low for 4 cycles:
  - lsu_reqValid is held for 5 cycles; lsu_wen=0.
  - reg_wen pulses once on lsu_respValid; a respValid during the pending phase is ignored.
- INST_STORE:
  - lsu_wen=1 with lsu_reqValid.
  - No reg_wen at any point; retired increments.
- TIMEOUT=8, IFU never responds → trap=1, trap_cause=3 at cycle 8 of FETCH, all reqValid low thereafter.
- Fetch with ifu_respErr=1 → trap_cause=1, no pc_wen.
- LSU error on a load → trap_cause=2, no reg_wen.
- halt_req=1 during a LOAD → load completes, EXEC, halted=1.
  - Dropping halt_req → ifu_reqValid next cycle.
  - INST_EBREAK → halted=1 with retired+1.
- reset_n pulsed low mid-STORE → all outputs 0 asynchronously, START restarts with the 10-cycle delay.

Source files
------------

// File: rtl/sm_ctrl_pkg.sv
// Shared definitions for the core sequencer: state encoding, decoded instruction classes, trap causes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sm_ctrl_pkg;

    // Seven legal states in three bits; the eighth encoding is treated as corruption.
    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_STORE = 3'd3,
        ST_EXEC  = 3'd4,
        ST_HALT  = 3'd5,
        ST_TRAP  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_FETCH   = 2'd1,
        CAUSE_LSU     = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } cause_t;

    // Decoded instruction classes as presented on inst_type.
    localparam int INST_ALU       = 0;
    localparam int INST_LOAD_BYTE = 1;
    localparam int INST_LOAD_HALF = 2;
    localparam int INST_LOAD_WORD = 3;
    localparam int INST_STORE     = 4;
    localparam int INST_BRANCH    = 5;
    localparam int INST_JUMP      = 6;
    localparam int INST_EBREAK    = 7;

endpackage

// File: rtl/sm_ctrl_if.sv
// Bundle between the sequencer and its IFU/LSU bus masters, decoder and debug/status sinks.
// Latency: n/a (wiring only).
// Backpressure: reqValid/reqReady per bus; responses carry no ready.
// master = sequencer side (drives requests, strobes, status); slave = bus/decoder side.
interface sm_ctrl_if #(
    parameter int INST_TYPE_W = 4,
    parameter int CNT_W       = 32
);
    logic [INST_TYPE_W-1:0] inst_type;
    logic                   ifu_reqReady;
    logic                   ifu_respValid;
    logic                   ifu_respErr;
    logic                   lsu_reqReady;
    logic                   lsu_respValid;
    logic                   lsu_respErr;
    logic                   halt_req;
    logic                   ifu_reqValid;
    logic                   lsu_reqValid;
    logic                   lsu_wen;
    logic                   pc_wen;
    logic                   reg_wen;
    logic                   halted;
    logic                   trap;
    logic [1:0]             trap_cause;
    logic [CNT_W-1:0]       retired;

    modport master (
        input  inst_type, ifu_reqReady, ifu_respValid, ifu_respErr,
               lsu_reqReady, lsu_respValid, lsu_respErr, halt_req,
        output ifu_reqValid, lsu_reqValid, lsu_wen, pc_wen, reg_wen,
               halted, trap, trap_cause, retired
    );

    modport slave (
        output inst_type, ifu_reqReady, ifu_respValid, ifu_respErr,
               lsu_reqReady, lsu_respValid, lsu_respErr, halt_req,
        input  ifu_reqValid, lsu_reqValid, lsu_wen, pc_wen, reg_wen,
               halted, trap, trap_cause, retired
    );

endinterface

// File: rtl/sm_ctrl_bus_hs_tracker.sv
// Tracks one request/response bus: pending request, response eligibility, response timeout.
// Latency: req_valid set on the start edge; resp_elig/timeout_hit are combinational.
// Backpressure: req_valid held until sampled with req_ready=1; responses ignored while pending.
// Ports: start (enter waiting state), active (waiting state current), abort (drop request),
//        req_ready/resp_valid from bus, req_valid to bus, resp_elig/timeout_hit to the FSM.
module sm_ctrl_bus_hs_tracker #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic active,
    input  logic abort,
    input  logic req_ready,
    input  logic resp_valid,
    output logic req_valid,
    output logic resp_elig,
    output logic timeout_hit
);

    // Counter only has to reach TIMEOUT-1: the terminal cycle is the TIMEOUT-th in the state.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tmo_cnt;

    // A response only counts once the request has been accepted on an earlier edge.
    assign resp_elig   = active && !req_valid && resp_valid;
    // An eligible response in the terminal cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT > 0) && active && !resp_elig && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_valid <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            if (start) begin
                req_valid <= 1'b1;
            end else if (abort || timeout_hit) begin
                req_valid <= 1'b0;
            end else if (req_valid && req_ready) begin
                req_valid <= 1'b0;
            end

            if (start) begin
                tmo_cnt <= '0;
            end else if (active) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/sm_ctrl.sv
// Core fetch/load/store/exec sequencer with bus timeouts, error traps, debug halt and retire counter.
// Latency: requests/status registered (set on the transition edge); pc_wen/reg_wen combinational.
// Backpressure: waits indefinitely on reqReady and respValid, bounded by TIMEOUT when nonzero.
// Ports: clock, reset_n (async active-low), bus (sm_ctrl_if.master: decoder type, IFU/LSU
//        handshakes, halt_req in; reqValids, lsu_wen, pc/reg strobes, halted/trap/cause, retired out).
module sm_ctrl #(
    parameter int START_DELAY = 10,
    parameter int TIMEOUT     = 64,
    parameter int INST_TYPE_W = 4,
    parameter int CNT_W       = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    sm_ctrl_if.master   bus
);
    import sm_ctrl_pkg::*;

    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    state_t           state;
    cause_t           cause;
    logic [DW-1:0]    dly_cnt;
    logic             halted_q;
    logic             trap_q;
    logic             lsu_wen_q;
    logic [CNT_W-1:0] retired_q;

    logic ifu_req, ifu_elig, ifu_tmo;
    logic lsu_req, lsu_elig, lsu_tmo;
    logic in_fetch, in_lsu, illegal, start_done, resume;
    logic is_load, is_store, is_ebreak;
    logic fetch_ok, fetch_err, lsu_ok, lsu_err, lsu_start;

    assign in_fetch  = (state == ST_FETCH);
    assign in_lsu    = (state == ST_LOAD) || (state == ST_STORE);
    assign illegal   = !(state inside {ST_START, ST_FETCH, ST_LOAD, ST_STORE, ST_EXEC, ST_HALT, ST_TRAP});

    assign start_done = (state == ST_START) &&
                        ((START_DELAY <= 1) || (dly_cnt == DW'(START_DELAY - 1)));

    assign is_load   = (bus.inst_type == INST_TYPE_W'(INST_LOAD_BYTE)) ||
                       (bus.inst_type == INST_TYPE_W'(INST_LOAD_HALF)) ||
                       (bus.inst_type == INST_TYPE_W'(INST_LOAD_WORD));
    assign is_store  = (bus.inst_type == INST_TYPE_W'(INST_STORE));
    assign is_ebreak = (bus.inst_type == INST_TYPE_W'(INST_EBREAK));

    assign fetch_ok  = in_fetch && ifu_elig && !bus.ifu_respErr;
    assign fetch_err = in_fetch && ifu_elig &&  bus.ifu_respErr;
    assign lsu_ok    = in_lsu && lsu_elig && !bus.lsu_respErr;
    assign lsu_err   = in_lsu && lsu_elig &&  bus.lsu_respErr;

    // Every path into FETCH: end of start delay, end of EXEC, leaving HALT; all gated by halt_req.
    assign resume    = !bus.halt_req && (start_done || (state == ST_EXEC) || (state == ST_HALT));
    assign lsu_start = fetch_ok && (is_load || is_store);

    assign bus.pc_wen  = fetch_ok;
    assign bus.reg_wen = (fetch_ok && !is_load && !is_store && !is_ebreak) ||
                         ((state == ST_LOAD) && lsu_ok);

    sm_ctrl_bus_hs_tracker #(.TIMEOUT(TIMEOUT)) u_ifu_hs (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (resume),
        .active      (in_fetch),
        .abort       (illegal),
        .req_ready   (bus.ifu_reqReady),
        .resp_valid  (bus.ifu_respValid),
        .req_valid   (ifu_req),
        .resp_elig   (ifu_elig),
        .timeout_hit (ifu_tmo)
    );

    sm_ctrl_bus_hs_tracker #(.TIMEOUT(TIMEOUT)) u_lsu_hs (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (lsu_start),
        .active      (in_lsu),
        .abort       (illegal),
        .req_ready   (bus.lsu_reqReady),
        .resp_valid  (bus.lsu_respValid),
        .req_valid   (lsu_req),
        .resp_elig   (lsu_elig),
        .timeout_hit (lsu_tmo)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_START;
            cause     <= CAUSE_NONE;
            dly_cnt   <= '0;
            halted_q  <= 1'b0;
            trap_q    <= 1'b0;
            lsu_wen_q <= 1'b0;
            retired_q <= '0;
        end else begin
            // Store flag lives exactly as long as the LSU request it qualifies.
            if (lsu_start) begin
                lsu_wen_q <= is_store;
            end else if (!in_lsu || (lsu_req && bus.lsu_reqReady) || lsu_tmo) begin
                lsu_wen_q <= 1'b0;
            end

            case (state)
                ST_START: begin
                    if (start_done) begin
                        dly_cnt <= '0;
                        if (bus.halt_req) begin
                            state    <= ST_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + DW'(1);
                    end
                end
                ST_FETCH: begin
                    if (fetch_err) begin
                        state  <= ST_TRAP;
                        trap_q <= 1'b1;
                        cause  <= CAUSE_FETCH;
                    end else if (fetch_ok) begin
                        if (is_load) begin
                            state <= ST_LOAD;
                        end else if (is_store) begin
                            state <= ST_STORE;
                        end else if (is_ebreak) begin
                            state     <= ST_HALT;
                            halted_q  <= 1'b1;
                            retired_q <= retired_q + CNT_W'(1);
                        end else begin
                            state <= ST_EXEC;
                        end
                    end else if (ifu_tmo) begin
                        state  <= ST_TRAP;
                        trap_q <= 1'b1;
                        cause  <= CAUSE_TIMEOUT;
                    end
                end
                ST_LOAD, ST_STORE: begin
                    if (lsu_err) begin
                        state  <= ST_TRAP;
                        trap_q <= 1'b1;
                        cause  <= CAUSE_LSU;
                    end else if (lsu_ok) begin
                        state <= ST_EXEC;
                    end else if (lsu_tmo) begin
                        state  <= ST_TRAP;
                        trap_q <= 1'b1;
                        cause  <= CAUSE_TIMEOUT;
                    end
                end
                ST_EXEC: begin
                    retired_q <= retired_q + CNT_W'(1);
                    if (bus.halt_req) begin
                        state    <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (!bus.halt_req) begin
                        state    <= ST_FETCH;
                        halted_q <= 1'b0;
                    end
                end
                ST_TRAP: begin
                    state <= ST_TRAP;
                end
                default: begin
                    // Corrupted encoding: park in TRAP rather than wedge.
                    state  <= ST_TRAP;
                    trap_q <= 1'b1;
                    cause  <= CAUSE_TIMEOUT;
                end
            endcase
        end
    end

    assign bus.ifu_reqValid = ifu_req;
    assign bus.lsu_reqValid = lsu_req;
    assign bus.lsu_wen      = lsu_wen_q;
    assign bus.halted       = halted_q;
    assign bus.trap         = trap_q;
    assign bus.trap_cause   = cause;
    assign bus.retired      = retired_q;

endmodule

// File: tb/tb_sm_ctrl.sv
// Directed bench for sm_ctrl: fetch/load/store/exec flows, halt/ebreak, traps, timeout, async reset.
// Latency: inputs driven 1 time unit after posedge; registered outputs sampled there, strobes 1 unit later.
// Backpressure: ready lines driven directly by the vectors below.
module tb_sm_ctrl;
    import sm_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    sm_ctrl_if #(.INST_TYPE_W(4), .CNT_W(32)) bus ();

    sm_ctrl #(
        .START_DELAY (10),
        .TIMEOUT     (8),
        .INST_TYPE_W (4),
        .CNT_W       (32)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bundle of every 1/2-bit output, order: ifu_req lsu_req lsu_wen pc_wen reg_wen halted trap cause[1:0].
    function automatic logic [8:0] outs();
        return {bus.ifu_reqValid, bus.lsu_reqValid, bus.lsu_wen, bus.pc_wen, bus.reg_wen,
                bus.halted, bus.trap, bus.trap_cause};
    endfunction

    // Advance one clock; response pulses are single-cycle unless re-driven.
    task automatic tick();
        @(posedge clock);
        #1;
        bus.ifu_respValid = 1'b0;
        bus.ifu_respErr   = 1'b0;
        bus.lsu_respValid = 1'b0;
        bus.lsu_respErr   = 1'b0;
    endtask

    // From FETCH cycle 1 with ifu_reqReady=1: accept, then present the response and let strobes settle.
    task automatic fetch_resp(input int ityp, input logic err);
        tick();
        bus.ifu_respValid = 1'b1;
        bus.ifu_respErr   = err;
        bus.inst_type     = 4'(ityp);
        #1;
    endtask

    task automatic reset_and_start();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check_eq("restart_ifu_req", 32'(bus.ifu_reqValid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.inst_type     = '0;
        bus.ifu_reqReady  = 1'b1;
        bus.ifu_respValid = 1'b0;
        bus.ifu_respErr   = 1'b0;
        bus.lsu_reqReady  = 1'b1;
        bus.lsu_respValid = 1'b0;
        bus.lsu_respErr   = 1'b0;
        bus.halt_req      = 1'b0;

        // Reset state and start delay, then an ALU instruction answered 3 cycles after acceptance.
        repeat (3) tick();
        check_eq("reset_outs", 32'(outs()), 32'd0);
        check_eq("reset_retired", bus.retired, 32'd0);
        reset_n = 1'b1;
        repeat (9) tick();
        check_eq("start_9_no_req", 32'(bus.ifu_reqValid), 32'd0);
        tick();
        check_eq("start_10_req", 32'(bus.ifu_reqValid), 32'd1);
        tick();
        check_eq("ifu_accept_clears", 32'(bus.ifu_reqValid), 32'd0);
        #1;
        check_eq("no_pc_wen_waiting", 32'(bus.pc_wen), 32'd0);
        tick();
        tick();
        bus.ifu_respValid = 1'b1;
        bus.inst_type     = 4'(INST_ALU);
        #1;
        check_eq("alu_pc_wen", 32'(bus.pc_wen), 32'd1);
        check_eq("alu_reg_wen", 32'(bus.reg_wen), 32'd1);
        tick();
        #1;
        check_eq("exec_no_strobes", 32'({bus.pc_wen, bus.reg_wen}), 32'd0);
        check_eq("exec_retired_before", bus.retired, 32'd0);
        tick();
        check_eq("alu_retired", bus.retired, 32'd1);
        check_eq("alu_refetch", 32'(bus.ifu_reqValid), 32'd1);

        // Load word with LSU stalled 4 cycles; early responses must be ignored.
        fetch_resp(INST_LOAD_WORD, 1'b0);
        check_eq("ld_pc_wen", 32'(bus.pc_wen), 32'd1);
        check_eq("ld_fetch_no_reg_wen", 32'(bus.reg_wen), 32'd0);
        bus.lsu_reqReady = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("ld_req_held_%0d", i), 32'({bus.lsu_reqValid, bus.lsu_wen}), 32'b10);
            bus.lsu_respValid = 1'b1;
            #1;
            check_eq($sformatf("ld_pending_resp_ignored_%0d", i), 32'(bus.reg_wen), 32'd0);
            tick();
        end
        check_eq("ld_req_held_4", 32'(bus.lsu_reqValid), 32'd1);
        bus.lsu_reqReady = 1'b1;
        tick();
        check_eq("ld_req_dropped", 32'(bus.lsu_reqValid), 32'd0);
        bus.lsu_respValid = 1'b1;
        #1;
        check_eq("ld_reg_wen", 32'(bus.reg_wen), 32'd1);
        tick();
        #1;
        check_eq("ld_exec_no_reg_wen", 32'(bus.reg_wen), 32'd0);
        tick();
        check_eq("ld_retired", bus.retired, 32'd2);

        // Store: lsu_wen with the request, never a register write.
        fetch_resp(INST_STORE, 1'b0);
        check_eq("st_fetch_strobes", 32'({bus.pc_wen, bus.reg_wen}), 32'b10);
        tick();
        check_eq("st_req_wen", 32'({bus.lsu_reqValid, bus.lsu_wen}), 32'b11);
        tick();
        check_eq("st_req_done", 32'({bus.lsu_reqValid, bus.lsu_wen}), 32'b00);
        bus.lsu_respValid = 1'b1;
        #1;
        check_eq("st_resp_no_reg_wen", 32'(bus.reg_wen), 32'd0);
        tick();
        #1;
        check_eq("st_exec_no_reg_wen", 32'(bus.reg_wen), 32'd0);
        tick();
        check_eq("st_retired", bus.retired, 32'd3);

        // halt_req raised during a load: load finishes, EXEC retires, then HALT.
        fetch_resp(INST_LOAD_BYTE, 1'b0);
        tick();
        bus.halt_req = 1'b1;
        tick();
        bus.lsu_respValid = 1'b1;
        #1;
        check_eq("halt_ld_reg_wen", 32'(bus.reg_wen), 32'd1);
        tick();
        check_eq("halt_exec_not_halted", 32'(bus.halted), 32'd0);
        tick();
        check_eq("halt_halted", 32'({bus.halted, bus.ifu_reqValid}), 32'b10);
        check_eq("halt_retired", bus.retired, 32'd4);
        tick();
        check_eq("halt_sticky_while_req", 32'(bus.halted), 32'd1);
        bus.halt_req = 1'b0;
        tick();
        check_eq("resume_ifu_req", 32'({bus.halted, bus.ifu_reqValid}), 32'b01);

        // EBREAK: halts with the instruction retired, resumes next cycle.
        fetch_resp(INST_EBREAK, 1'b0);
        check_eq("ebreak_strobes", 32'({bus.pc_wen, bus.reg_wen}), 32'b10);
        tick();
        check_eq("ebreak_halted", 32'({bus.halted, bus.ifu_reqValid}), 32'b10);
        check_eq("ebreak_retired", bus.retired, 32'd5);
        tick();
        check_eq("ebreak_resume", 32'({bus.halted, bus.ifu_reqValid}), 32'b01);

        // Asynchronous reset in the middle of a store.
        fetch_resp(INST_STORE, 1'b0);
        bus.lsu_reqReady = 1'b0;
        tick();
        check_eq("pre_reset_store_req", 32'(bus.lsu_reqValid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("async_reset_outs", 32'(outs()), 32'd0);
        check_eq("async_reset_retired", bus.retired, 32'd0);
        bus.lsu_reqReady = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (9) tick();
        check_eq("restart_9_no_req", 32'(bus.ifu_reqValid), 32'd0);
        tick();
        check_eq("restart_10_req", 32'(bus.ifu_reqValid), 32'd1);

        // Fetch bus error: trap cause 1, no strobes, sticky.
        fetch_resp(INST_ALU, 1'b1);
        check_eq("ferr_no_strobes", 32'({bus.pc_wen, bus.reg_wen}), 32'd0);
        tick();
        check_eq("ferr_trap", 32'(outs()), 32'b0_0000_0101);
        tick();
        tick();
        check_eq("ferr_trap_sticky", 32'(outs()), 32'b0_0000_0101);

        // LSU error on a load: trap cause 2, no register write.
        reset_and_start();
        fetch_resp(INST_LOAD_HALF, 1'b0);
        tick();
        tick();
        bus.lsu_respValid = 1'b1;
        bus.lsu_respErr   = 1'b1;
        #1;
        check_eq("lerr_no_reg_wen", 32'(bus.reg_wen), 32'd0);
        tick();
        check_eq("lerr_trap", 32'(outs()), 32'b0_0000_0110);

        // Response in the 8th FETCH cycle beats the timeout.
        reset_and_start();
        tick();
        repeat (6) tick();
        bus.ifu_respValid = 1'b1;
        bus.inst_type     = 4'(INST_BRANCH);
        #1;
        check_eq("tmo_edge_pc_wen", 32'(bus.pc_wen), 32'd1);
        tick();
        check_eq("tmo_edge_no_trap", 32'(bus.trap), 32'd0);
        tick();
        check_eq("tmo_edge_retired", bus.retired, 32'd1);

        // IFU never accepts nor responds: trap at the end of FETCH cycle 8.
        bus.ifu_reqReady = 1'b0;
        repeat (7) tick();
        check_eq("tmo_cycle8_pending", 32'({bus.trap, bus.ifu_reqValid}), 32'b01);
        tick();
        check_eq("tmo_trap", 32'(outs()), 32'b0_0000_0111);
        bus.ifu_reqReady = 1'b1;
        repeat (3) tick();
        check_eq("tmo_trap_sticky", 32'(outs()), 32'b0_0000_0111);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
